// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver for the CPU's memory-mapped key port.
//
// Deserialises PS/2 device-to-host frames (start, 8 data bits LSB first,
// odd parity, stop) and drops extended prefixes (0xE0), break prefixes
// (0xF0) and the key code that follows a break. Make codes are held until
// the memory subsystem consumes them with a rising edge on clean_key_buffer.
//
// Build option: define KEY_FIFO_EN for a FIFO_DEPTH-entry circular FIFO;
// without it a single holding register (depth 1) is used.
//
// Ports:
//   CLK_CPU          in   system clock, all logic is on this clock
//   RST_N            in   asynchronous active-low reset
//   ps2_clk          in   raw PS/2 clock pin (asynchronous)
//   ps2_data         in   raw PS/2 data pin (asynchronous)
//   clean_key_buffer in   pop request level; only its rising edge pops
//   pressed_key      out  oldest buffered make code, 0x00 when empty
//   key_valid        out  high while the buffer is non-empty
//   frame_err        out  1-cycle pulse on start/parity/stop error or timeout
//   overflow         out  1-cycle pulse when a key is dropped (buffer full)
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK_CPU,
  input  logic       RST_N,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clean_key_buffer,
  output logic [7:0] pressed_key,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  // True when data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          clean_prev_q;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          brk_q, brk_d;
  logic [7:0]    pressed_key_q;
  logic          key_valid_q, frame_err_q, overflow_q;

  logic          fall_s, data_s, pop_req_s;
  logic          err_s, byte_ok_s, push_s;
  logic          empty_s, full_s;
  logic          do_push_s, do_pop_s, ovf_s;
  logic [7:0]    head_d;
  logic          valid_d;

  // Two-flop synchronisers on the PS/2 pins plus edge-history flops.
  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      clean_prev_q <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      clean_prev_q <= clean_key_buffer;
    end
  end

  assign fall_s    = clk_prev_q & ~clk_s2_q;
  assign data_s    = dat_s2_q;
  // A held-high request pops only once.
  assign pop_req_s = clean_key_buffer & ~clean_prev_q;

  // Receive FSM next state, frame error and inter-edge timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_cnt_d = tmo_cnt_q;
    err_s     = 1'b0;
    byte_ok_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_s) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_s) begin
          par_d   = data_s;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          state_d = S_IDLE;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            byte_ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Counter value k means k+1 cycles have elapsed since the last edge.
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
    end else if (fall_s) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_cnt_d = '0;
      state_d   = S_IDLE;
      shift_d   = 8'h00;
      err_s     = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // Make/break filter on each complete, error-free byte.
  always_comb begin
    brk_d  = brk_q;
    push_s = 1'b0;
    if (byte_ok_s) begin
      if (shift_q == 8'hE0) begin
        brk_d = brk_q;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (shift_q != 8'h00) begin
        push_s = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end else begin
      brk_d = brk_q;
    end
  end

  // Push/pop arbitration: a pop frees room for a same-cycle push.
  always_comb begin
    do_pop_s  = pop_req_s & ~empty_s;
    do_push_s = push_s & (~full_s | do_pop_s);
    ovf_s     = push_s & full_s & ~do_pop_s;
  end

`ifdef KEY_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;

  // Occupancy flags from the extra pointer bit.
  always_comb begin
    empty_s = (wr_q == rd_q);
    full_s  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  end

  // Pointer update and next head value for the registered outputs.
  always_comb begin
    if (do_push_s) begin
      wr_d = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (wr_d == rd_d) begin
      head_d = 8'h00;
    end else if (do_push_s && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      head_d = shift_q;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
    valid_d = (wr_d != rd_d);
  end

  // FIFO storage and pointers.
  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q[AW-1:0]] <= shift_q;
      end
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
`else
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;

  // Single-entry occupancy flags.
  always_comb begin
    empty_s = ~full_q;
    full_s  = full_q;
  end

  // Holding register update; it reads 0x00 whenever it is empty.
  always_comb begin
    if (do_push_s) begin
      hold_d = shift_q;
      full_d = 1'b1;
    end else if (do_pop_s) begin
      hold_d = 8'h00;
      full_d = 1'b0;
    end else begin
      hold_d = hold_q;
      full_d = full_q;
    end
    head_d  = hold_d;
    valid_d = full_d;
  end

  // Holding register and full flag.
  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
    end
  end
`endif

  // Receiver state, filter state and registered outputs.
  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      par_q         <= 1'b0;
      tmo_cnt_q     <= '0;
      brk_q         <= 1'b0;
      pressed_key_q <= 8'h00;
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      tmo_cnt_q     <= tmo_cnt_d;
      brk_q         <= brk_d;
      pressed_key_q <= head_d;
      key_valid_q   <= valid_d;
      frame_err_q   <= err_s;
      overflow_q    <= ovf_s;
    end
  end

  assign pressed_key = pressed_key_q;
  assign key_valid   = key_valid_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule
